crc16_checker: RTL

Receive-side companion to the byte-wise CRC-16/CCITT generator: consumes a byte stream whose frames end in a 2-byte CRC (MSB byte first), checks the CRC over each frame, and forwards the payload with the CRC bytes stripped. Sits between the link byte receiver and the frame consumer. CRC parameters are fixed: polynomial 0x1021, init 0xFFFF, MSB-first, no reflection, no final XOR. A frame is good when the CRC register reads 0x0000 after the last CRC byte.

---
 rtl/crc16_checker.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/crc16_checker.sv
// Receive-side CRC-16/CCITT checker: strips the trailing 2-byte CRC, forwards the payload,
// and reports per-frame status. Define CRC16_CHK_STAT_EN to build the frame/error counters.
module crc16_checker (
   input  logic        clk,
   input  logic        rst,
   input  logic        s_valid,
   input  logic [7:0]  s_data,
   input  logic        s_last,
   output logic        s_ready,
   output logic        m_valid,
   output logic [7:0]  m_data,
   output logic        m_last,
   input  logic        m_ready,
   output logic        frame_done,
   output logic        frame_ok,
   output logic        runt,
   output logic [15:0] crc_value,
   output logic [15:0] frame_cnt,
   output logic [15:0] err_cnt
);

   typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [7:0]  slot0_q, slot0_d;
   logic [7:0]  slot1_q, slot1_d;
   logic        m_valid_q, m_valid_d;
   logic [7:0]  m_data_q, m_data_d;
   logic        m_last_q, m_last_d;
   logic [15:0] crc_q, crc_d;
   logic [1:0]  len_q, len_d;
   logic        done_q, done_d;
   logic        ok_q, ok_d;
   logic        runt_q, runt_d;
   logic        accept_s;
   logic [15:0] crc_next_s;

   function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic [7:0] data);
      logic [15:0] c;
      c = crc ^ {data, 8'h00};
      for (int i = 0; i < 8; i++) begin
         if (c[15]) begin
            c = {c[14:0], 1'b0} ^ 16'h1021;
         end else begin
            c = {c[14:0], 1'b0};
         end
      end
      return c;
   endfunction

   // Only a full pipe with a stalled output register blocks the input.
   assign s_ready    = !((cnt_q == 2'd2) && m_valid_q && !m_ready);
   assign accept_s   = s_valid && s_ready;
   assign crc_next_s = crc_step(crc_q, s_data);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept_s && !s_last) begin
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (accept_s && s_last) begin
               state_d = IDLE;
            end else begin
               state_d = RUN;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cnt_d     = cnt_q;
      slot0_d   = slot0_q;
      slot1_d   = slot1_q;
      m_data_d  = m_data_q;
      m_last_d  = m_last_q;
      crc_d     = crc_q;
      len_d     = len_q;
      done_d    = 1'b0;
      ok_d      = ok_q;
      runt_d    = runt_q;
      if (m_valid_q && m_ready) begin
         m_valid_d = 1'b0;
      end else begin
         m_valid_d = m_valid_q;
      end

      if (accept_s) begin
         // The oldest slot leaves only once two younger bytes are behind it.
         if (cnt_q == 2'd2) begin
            m_valid_d = 1'b1;
            m_data_d  = slot0_q;
            m_last_d  = s_last;
         end else begin
            m_data_d  = m_data_q;
         end

         if (s_last) begin
            cnt_d  = 2'd0;
            crc_d  = 16'hFFFF;
            len_d  = 2'd0;
            done_d = 1'b1;
            ok_d   = (crc_next_s == 16'h0000) && (len_q >= 2'd2);
            runt_d = (len_q < 2'd2);
         end else begin
            crc_d = crc_next_s;
            if (len_q != 2'd3) begin
               len_d = len_q + 2'd1;
            end else begin
               len_d = len_q;
            end
            if (cnt_q == 2'd2) begin
               slot0_d = slot1_q;
               slot1_d = s_data;
            end else if (cnt_q == 2'd1) begin
               slot1_d = s_data;
               cnt_d   = 2'd2;
            end else begin
               slot0_d = s_data;
               cnt_d   = 2'd1;
            end
         end
      end else begin
         crc_d = crc_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= 2'd0;
         slot0_q   <= 8'h00;
         slot1_q   <= 8'h00;
         m_valid_q <= 1'b0;
         m_data_q  <= 8'h00;
         m_last_q  <= 1'b0;
         crc_q     <= 16'hFFFF;
         len_q     <= 2'd0;
         done_q    <= 1'b0;
         ok_q      <= 1'b0;
         runt_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         slot0_q   <= slot0_d;
         slot1_q   <= slot1_d;
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
         m_last_q  <= m_last_d;
         crc_q     <= crc_d;
         len_q     <= len_d;
         done_q    <= done_d;
         ok_q      <= ok_d;
         runt_q    <= runt_d;
      end
   end

   assign m_valid    = m_valid_q;
   assign m_data     = m_data_q;
   assign m_last     = m_last_q;
   assign frame_done = done_q;
   assign frame_ok   = ok_q;
   assign runt       = runt_q;
   assign crc_value  = crc_q;

`ifdef CRC16_CHK_STAT_EN
   logic [15:0] frame_cnt_q;
   logic [15:0] err_cnt_q;

   // Counters advance together with the rising status pulse and saturate.
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_cnt_q <= 16'h0000;
         err_cnt_q   <= 16'h0000;
      end else begin
         if (done_d && (frame_cnt_q != 16'hFFFF)) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
         end else begin
            frame_cnt_q <= frame_cnt_q;
         end
         if (done_d && !ok_d && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
         end else begin
            err_cnt_q <= err_cnt_q;
         end
      end
   end

   assign frame_cnt = frame_cnt_q;
   assign err_cnt   = err_cnt_q;
`else
   assign frame_cnt = 16'h0000;
   assign err_cnt   = 16'h0000;
`endif

endmodule
